// File: rtl/instr_aligner.sv
// -----------------------------------------------------------------------------
// instr_aligner
//   Fetch-side stage ahead of instruction identify. Buffers 32-bit fetch words
//   in a small FIFO and presents one complete instruction at a time as a 64-bit
//   word: {prefix, suffix} for prefixed instructions (primary opcode 1), or
//   {word, 32'b0} otherwise. Tracks the PC of the instruction at the FIFO head.
//
// Ports
//   i_clk          clock, all state updates on posedge
//   i_rst          asynchronous active-low reset
//   i_redirect     flush FIFO and load i_redirect_pc (highest priority)
//   i_redirect_pc  PC of the first word fetched after a redirect
//   i_fetch_valid  fetch word present on i_fetch_word
//   i_fetch_word   fetch word, big-endian (bit 0 = MSB)
//   o_fetch_ready  FIFO can accept a word this cycle
//   o_en           complete instruction present on o_instr
//   o_instr        assembled instruction, zero when o_en is low
//   o_prefixed     o_instr is an 8-byte prefixed instruction (only with o_en)
//   o_pc           PC of the head instruction
//   i_ready        downstream consumes o_instr when o_en & i_ready
// -----------------------------------------------------------------------------
module instr_aligner #(
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_redirect,
  input  logic [0:63]  i_redirect_pc,
  input  logic         i_fetch_valid,
  input  logic [0:31]  i_fetch_word,
  output logic         o_fetch_ready,
  output logic         o_en,
  output logic [0:63]  o_instr,
  output logic         o_prefixed,
  output logic [0:63]  o_pc,
  input  logic         i_ready
);

  localparam int              PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [5:0]      PREFIX_OPCD = 6'b000001;

  logic [0:31]      mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [0:63]      pc_r;
  // Low while in reset and high from the first edge after release; keeps
  // o_fetch_ready at 0 during reset even though the FIFO is empty.
  logic             live_r;

  logic [PTR_W-1:0] next_ptr_s;
  logic [0:31]      head_word_s;
  logic [0:31]      suffix_word_s;
  logic             head_prefixed_s;
  logic             en_s;
  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] pop_size_s;
  logic [CNT_W-1:0] count_next_s;
  logic [0:63]      pc_step_s;
  logic [0:63]      instr_s;

  assign next_ptr_s      = rd_ptr_r + PTR_W'(1);
  assign head_word_s     = mem_r[rd_ptr_r];
  assign suffix_word_s   = mem_r[next_ptr_s];
  assign head_prefixed_s = (head_word_s[0:5] == PREFIX_OPCD);

  // Instruction-complete decode: a prefix needs its suffix in the FIFO too.
  always_comb begin
    en_s = 1'b0;
    if (head_prefixed_s) begin
      en_s = (count_r >= CNT_W'(2));
    end else begin
      en_s = (count_r >= CNT_W'(1));
    end
  end

  // Ready depends only on registered occupancy: a full FIFO refuses a push
  // even in a cycle where a pop frees space.
  assign ready_s = live_r & (count_r < DEPTH_C);
  assign push_s  = i_fetch_valid & ready_s & ~i_redirect;
  assign pop_s   = en_s & i_ready & ~i_redirect;

  // Pop size, PC step and occupancy update for the current cycle.
  always_comb begin
    pop_size_s = CNT_W'(1);
    pc_step_s  = 64'd4;
    if (head_prefixed_s) begin
      pop_size_s = CNT_W'(2);
      pc_step_s  = 64'd8;
    end else begin
      pop_size_s = CNT_W'(1);
      pc_step_s  = 64'd4;
    end
    count_next_s = count_r + CNT_W'(push_s) - (pop_s ? pop_size_s : CNT_W'(0));
  end

  // Output word assembly; zero whenever no complete instruction is present.
  always_comb begin
    instr_s = 64'd0;
    if (en_s) begin
      if (head_prefixed_s) begin
        instr_s = {head_word_s, suffix_word_s};
      end else begin
        instr_s = {head_word_s, 32'd0};
      end
    end else begin
      instr_s = 64'd0;
    end
  end

  assign o_fetch_ready = ready_s;
  assign o_en          = en_s;
  assign o_instr       = instr_s;
  assign o_prefixed    = en_s & head_prefixed_s;
  assign o_pc          = pc_r;

  // FIFO storage, pointers, occupancy and head PC; redirect overrides push/pop.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      pc_r     <= 64'd0;
      live_r   <= 1'b0;
    end else begin
      live_r <= 1'b1;
      if (i_redirect) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
        count_r  <= '0;
        pc_r     <= i_redirect_pc;
      end else begin
        if (push_s) begin
          mem_r[wr_ptr_r] <= i_fetch_word;
          wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s) begin
          // Pointer width equals log2(DEPTH), so the add wraps around the ring.
          rd_ptr_r <= rd_ptr_r + pop_size_s[PTR_W-1:0];
          pc_r     <= pc_r + pc_step_s;
        end else begin
          rd_ptr_r <= rd_ptr_r;
          pc_r     <= pc_r;
        end
        count_r <= count_next_s;
      end
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
module tb_instr_aligner;

  logic         i_clk;
  logic         i_rst;
  logic         i_redirect;
  logic [63:0]  i_redirect_pc;
  logic         i_fetch_valid;
  logic [31:0]  i_fetch_word;
  logic         o_fetch_ready;
  logic         o_en;
  logic [63:0]  o_instr;
  logic         o_prefixed;
  logic [63:0]  o_pc;
  logic         i_ready;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Scoreboard: words the DUT must hold, in order, plus the expected head PC.
  logic [31:0] exp_q[$];
  logic [63:0] m_pc   = 64'd0;
  logic        m_live = 1'b0;

  instr_aligner #(.DEPTH(4)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_fetch_valid (i_fetch_valid),
    .i_fetch_word  (i_fetch_word),
    .o_fetch_ready (o_fetch_ready),
    .o_en          (o_en),
    .o_instr       (o_instr),
    .o_prefixed    (o_prefixed),
    .o_pc          (o_pc),
    .i_ready       (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic exp_pref();
    return (exp_q.size() >= 1) && (exp_q[0][31:26] == 6'b000001);
  endfunction

  function automatic logic exp_en();
    if (exp_q.size() == 0) return 1'b0;
    if (exp_pref()) return exp_q.size() >= 2;
    return 1'b1;
  endfunction

  function automatic logic [63:0] exp_instr();
    if (!exp_en()) return 64'd0;
    if (exp_pref()) return {exp_q[0], exp_q[1]};
    return {exp_q[0], 32'd0};
  endfunction

  function automatic logic exp_ready();
    return m_live && (exp_q.size() < 4);
  endfunction

  // Drive one cycle of stimulus and advance the scoreboard across the edge.
  task automatic drive_cycle(input logic v, input logic [31:0] w, input logic rdy,
                             input logic redir, input logic [63:0] rpc);
    logic en_b, pref_b, push_b;
    i_fetch_valid = v;
    i_fetch_word  = w;
    i_ready       = rdy;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    en_b   = exp_en();
    pref_b = exp_pref();
    push_b = v && exp_ready() && !redir;
    @(posedge i_clk);
    if (!i_rst) begin
      exp_q.delete();
      m_pc   = 64'd0;
      m_live = 1'b0;
    end else begin
      if (redir) begin
        exp_q.delete();
        m_pc = rpc;
      end else begin
        if (en_b && rdy) begin
          void'(exp_q.pop_front());
          if (pref_b) begin
            void'(exp_q.pop_front());
            m_pc = m_pc + 64'd8;
          end else begin
            m_pc = m_pc + 64'd4;
          end
        end
        if (push_b) exp_q.push_back(w);
      end
      m_live = 1'b1;
    end
    #1;
    i_fetch_valid = 1'b0;
    i_ready       = 1'b0;
    i_redirect    = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    chk_cnt++; if (o_en !== 1'b0) $display("FAIL rst_en: got %0b want 0", o_en); else pass_cnt++;
    chk_cnt++; if (o_fetch_ready !== 1'b0) $display("FAIL rst_ready: got %0b want 0", o_fetch_ready); else pass_cnt++;
    chk_cnt++; if (o_instr !== 64'd0) $display("FAIL rst_instr: got %h want 0", o_instr); else pass_cnt++;
    chk_cnt++; if (o_prefixed !== 1'b0) $display("FAIL rst_prefixed: got %0b want 0", o_prefixed); else pass_cnt++;
    chk_cnt++; if (o_pc !== 64'd0) $display("FAIL rst_pc: got %h want 0", o_pc); else pass_cnt++;
    i_rst = 1'b1;
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    chk_cnt++; if (o_fetch_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b want 1", o_fetch_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b1, 64'h1000);
    drive_cycle(1'b1, 32'h48032BFB, 1'b1, 1'b0, 64'd0);
    chk_cnt++; if (o_en !== 1'b1) $display("FAIL basic_en: got %0b want 1", o_en); else pass_cnt++;
    chk_cnt++; if (o_instr !== exp_instr()) $display("FAIL basic_instr: got %h want %h", o_instr, exp_instr()); else pass_cnt++;
    chk_cnt++; if (o_prefixed !== 1'b0) $display("FAIL basic_prefixed: got %0b want 0", o_prefixed); else pass_cnt++;
    chk_cnt++; if (o_pc !== 64'h1000) $display("FAIL basic_pc: got %h want 1000", o_pc); else pass_cnt++;
    drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
    chk_cnt++; if (o_pc !== 64'h1004) $display("FAIL basic_pc_after_pop: got %h want 1004", o_pc); else pass_cnt++;
    chk_cnt++; if (o_en !== 1'b0) $display("FAIL basic_en_after_pop: got %0b want 0", o_en); else pass_cnt++;
  endtask

  task automatic test_prefix();
    logic [63:0] pc0;
    drive_cycle(1'b1, 32'h04000000, 1'b1, 1'b0, 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk_cnt++; if (o_en !== 1'b0) $display("FAIL prefix_lone_en[%0d]: got %0b want 0", k, o_en); else pass_cnt++;
      chk_cnt++; if (o_prefixed !== 1'b0) $display("FAIL prefix_lone_pref[%0d]: got %0b want 0", k, o_prefixed); else pass_cnt++;
      if (k < 2) drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
    end
    drive_cycle(1'b1, 32'h38600001, 1'b1, 1'b0, 64'd0);
    pc0 = m_pc;
    chk_cnt++; if (o_en !== 1'b1) $display("FAIL prefix_en: got %0b want 1", o_en); else pass_cnt++;
    chk_cnt++; if (o_instr !== 64'h04000000_38600001) $display("FAIL prefix_instr: got %h want 0400000038600001", o_instr); else pass_cnt++;
    chk_cnt++; if (o_prefixed !== 1'b1) $display("FAIL prefix_pref: got %0b want 1", o_prefixed); else pass_cnt++;
    chk_cnt++; if (o_pc !== pc0) $display("FAIL prefix_pc: got %h want %h", o_pc, pc0); else pass_cnt++;
    drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
    chk_cnt++; if (o_pc !== pc0 + 64'd8) $display("FAIL prefix_pc_after_pop: got %h want %h", o_pc, pc0 + 64'd8); else pass_cnt++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 32'h60000010 + 32'(i), 1'b0, 1'b0, 64'd0);
      chk_cnt++; if (o_fetch_ready !== exp_ready()) $display("FAIL full_ready[%0d]: got %0b want %0b", i, o_fetch_ready, exp_ready()); else pass_cnt++;
    end
    chk_cnt++; if (o_fetch_ready !== 1'b0) $display("FAIL full_ready_after4: got %0b want 0", o_fetch_ready); else pass_cnt++;
    drive_cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 64'd0);
    chk_cnt++; if (o_instr !== {32'h60000010, 32'd0}) $display("FAIL full_head: got %h want 6000001000000000", o_instr); else pass_cnt++;
    // Full FIFO with push and pop together: the push is refused.
    drive_cycle(1'b1, 32'hBAD00000, 1'b1, 1'b0, 64'd0);
    chk_cnt++; if (o_fetch_ready !== 1'b1) $display("FAIL full_pushpop_ready: got %0b want 1", o_fetch_ready); else pass_cnt++;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      chk_cnt++;
      if ({o_en, o_prefixed, o_instr, o_pc} !== {exp_en(), exp_en() & exp_pref(), exp_instr(), m_pc})
        $display("FAIL full_drain[%0d]: got en=%0b instr=%h pc=%h want en=%0b instr=%h pc=%h",
                 k, o_en, o_instr, o_pc, exp_en(), exp_instr(), m_pc);
      else pass_cnt++;
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
    end
    chk_cnt++; if (o_en !== 1'b0) $display("FAIL full_drained_en: got %0b want 0", o_en); else pass_cnt++;
  endtask

  task automatic test_redirect();
    drive_cycle(1'b1, 32'h11111111, 1'b0, 1'b0, 64'd0);
    drive_cycle(1'b1, 32'h22222222, 1'b0, 1'b0, 64'd0);
    drive_cycle(1'b1, 32'h33333333, 1'b1, 1'b1, 64'h2000);
    chk_cnt++; if (o_en !== 1'b0) $display("FAIL redir_en: got %0b want 0", o_en); else pass_cnt++;
    chk_cnt++; if (o_pc !== 64'h2000) $display("FAIL redir_pc: got %h want 2000", o_pc); else pass_cnt++;
    chk_cnt++; if (o_fetch_ready !== 1'b1) $display("FAIL redir_ready: got %0b want 1", o_fetch_ready); else pass_cnt++;
    drive_cycle(1'b1, 32'h44444444, 1'b0, 1'b0, 64'd0);
    chk_cnt++; if (o_instr !== {32'h44444444, 32'd0}) $display("FAIL redir_next_instr: got %h want 4444444400000000", o_instr); else pass_cnt++;
    drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
    chk_cnt++; if (o_pc !== 64'h2004) $display("FAIL redir_pc_after_pop: got %h want 2004", o_pc); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic need_suffix = 1'b0;
    logic [31:0] w;
    for (int i = 0; i < 24; i++) begin
      chk_cnt++;
      if ({o_en, o_prefixed, o_instr, o_pc} !== {exp_en(), exp_en() & exp_pref(), exp_instr(), m_pc})
        $display("FAIL b2b[%0d]: got en=%0b instr=%h pc=%h want en=%0b instr=%h pc=%h",
                 i, o_en, o_instr, o_pc, exp_en(), exp_instr(), m_pc);
      else pass_cnt++;
      if (need_suffix) begin
        w = 32'h38600000 | 32'(i);
        need_suffix = 1'b0;
      end else if ((i % 3) == 0) begin
        w = 32'h04000000 | 32'(i);
        need_suffix = 1'b1;
      end else begin
        w = 32'h60000000 | 32'($urandom_range(0, 65535));
      end
      drive_cycle(1'b1, w, 1'b1, 1'b0, 64'd0);
    end
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
    chk_cnt++; if (o_en !== 1'b0) $display("FAIL b2b_drained_en: got %0b want 0", o_en); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h7C000000 + 32'(i), 1'b0, 1'b0, 64'd0);
    chk_cnt++; if (o_en !== 1'b1) $display("FAIL rmid_pre_en: got %0b want 1", o_en); else pass_cnt++;
    #2;
    i_rst = 1'b0;
    #1;
    chk_cnt++; if (o_en !== 1'b0) $display("FAIL rmid_en: got %0b want 0", o_en); else pass_cnt++;
    chk_cnt++; if (o_fetch_ready !== 1'b0) $display("FAIL rmid_ready: got %0b want 0", o_fetch_ready); else pass_cnt++;
    chk_cnt++; if (o_instr !== 64'd0) $display("FAIL rmid_instr: got %h want 0", o_instr); else pass_cnt++;
    chk_cnt++; if (o_prefixed !== 1'b0) $display("FAIL rmid_prefixed: got %0b want 0", o_prefixed); else pass_cnt++;
    chk_cnt++; if (o_pc !== 64'd0) $display("FAIL rmid_pc: got %h want 0", o_pc); else pass_cnt++;
    drive_cycle(1'b1, 32'h11111111, 1'b0, 1'b0, 64'd0);
    i_rst = 1'b1;
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    chk_cnt++; if (o_fetch_ready !== 1'b1) $display("FAIL rmid_release_ready: got %0b want 1", o_fetch_ready); else pass_cnt++;
    chk_cnt++; if (o_en !== 1'b0) $display("FAIL rmid_release_en: got %0b want 0", o_en); else pass_cnt++;
    drive_cycle(1'b1, 32'h48032BFB, 1'b0, 1'b0, 64'd0);
    chk_cnt++; if ({o_en, o_instr, o_pc} !== {1'b1, 32'h48032BFB, 32'd0, 64'd0})
      $display("FAIL rmid_resume: got en=%0b instr=%h pc=%h want en=1 instr=48032bfb00000000 pc=0", o_en, o_instr, o_pc);
    else pass_cnt++;
  endtask

  initial begin
    i_rst         = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 64'd0;
    i_fetch_valid = 1'b0;
    i_fetch_word  = 32'd0;
    i_ready       = 1'b0;
    test_reset();
    test_basic();
    test_prefix();
    test_full();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
